display_scan_ctrl: RTL
======================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller that shares one Display7Seg decoder among NUM_DIGITS
//  common-anode digits. Holds one 5-bit code per digit in a double-buffered register file.
//  Drives the shared 5-bit code bus and one active-low digit select at a time.
//  Sits between the ALU/result logic (the writer) and the decoder plus board anodes.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned, 2..8
//  PRESCALE     50000  clk cycles per digit slot, >= 4
//  BLANK_CYCLES 500    leading cycles of each slot with all digits off (anti-ghost); < PRESCALE
// PORTS
//  clk         in   1                   system clock, rising edge
//  rst_n       in   1                   async active-low reset
//  enable      in   1                   1 = scanning; 0 = display off
//  wr_en       in   1                   write wr_data into shadow[wr_addr]
//  wr_addr     in   $clog2(NUM_DIGITS)  shadow slot index; values >= NUM_DIGITS are ignored
//  wr_data     in   5                   code written to the slot (Display7Seg encoding)
//  commit_req  in   1                   level request: copy shadow bank to active bank
//  commit_ack  out  1                   1-cycle pulse when the copy occurs
//  code_out    out  5                   active[idx], to the shared decoder inBits
//  digit_sel   out  NUM_DIGITS          active-low one-hot anode enables
//  frame_start out  1                   1-cycle pulse when idx wraps to 0
// BEHAVIOUR
//  Reset: state=OFF, idx=0, prescaler cnt=0.
//   Both banks 0, code_out=0, digit_sel=all 1s, commit_ack=0, frame_start=0.
//  Prescaler: cnt counts 0..PRESCALE-1 while state!=OFF; slot_end = (cnt==PRESCALE-1).
//  FSM:
//   OFF: enable=1 -> BLANK with cnt=0, idx=0, frame_start=1 that cycle.
//   BLANK: digit_sel all 1s; cnt==BLANK_CYCLES-1 -> SHOW.
//   SHOW: digit_sel[idx]=0, all other bits 1; slot_end -> BLANK with idx=idx+1.
//    idx wraps NUM_DIGITS-1 -> 0; frame_start=1 in the first BLANK cycle after the wrap.
//   enable=0 in any state -> OFF next cycle; cnt and idx cleared; digit_sel all 1s.
//  Outputs: code_out = active[idx] in BLANK and SHOW, 0 in OFF; registered, 0-cycle lag vs state.
//  Write: wr_en is accepted every cycle with no backpressure.
//   Shadow slot updates on the next edge; the active bank never changes on a write.
//  Commit (frame boundary): copy occurs on the edge ending the last slot (idx=NUM_DIGITS-1,
//   slot_end, commit_req=1). commit_ack=1 for the next cycle. The new codes appear at idx 0.
//  Commit while OFF: copy on the first edge with commit_req=1; ack the next cycle.
//  Requester must hold commit_req until ack and drop it in the ack cycle.
//   If commit_req is still 1 after the ack cycle, it is a new request.
//  Write and copy in the same cycle: active receives the pre-write shadow value.
//   The write still lands in shadow.
//  Reset asserted mid-slot: immediate return to reset values; no partial commit survives.
// CONFIGURATION
//  DISPLAY_DIM_EN defined:
//   Adds input `dim` (1 bit). When dim=1, SHOW drives digit_sel[idx] low only while
//   cnt < BLANK_CYCLES + (PRESCALE-BLANK_CYCLES)/2, and all 1s for the rest of the slot.
//   State and idx timing are unchanged.
//  DISPLAY_DIM_EN undefined: no dim port; full-width SHOW window.
// TESTING (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
//  Reset release, enable=1 -> frame_start pulse; digit_sel=1111 for 2 cycles,
//   then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101.
//  Write 5'h01,02,03,04 to slots 0..3 with no commit -> code_out stays 0 for all slots.
//   Pulse commit_req -> ack at the frame boundary; next frame shows 01,02,03,04 in order.
//  Write slot 3 = 5'h1F in the same cycle as the commit copy -> the following frame shows
//   the old slot 3 value; the next commit shows 1F.
//  wr_addr out of range (only when NUM_DIGITS < 2^width) -> no bank change.
//  enable dropped mid-SHOW at idx=2 -> next cycle digit_sel=1111, code_out=0.
//   Re-enable -> restarts at idx 0 with a frame_start pulse.
//  commit_req while OFF -> commit_ack exactly 2 edges after request.
//  DISPLAY_DIM_EN with dim=1 -> digit_sel low for cycles 2..4 of each slot only (3 of 8).

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bus between the result writer and the display scan controller.
// The optional dim line exists only when DISPLAY_DIM_EN is defined.
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                          enable;
    logic                          wr_en;
    logic [$clog2(NUM_DIGITS)-1:0] wr_addr;
    logic [4:0]                    wr_data;
    logic                          commit_req;
    logic                          commit_ack;
    logic [4:0]                    code_out;
    logic [NUM_DIGITS-1:0]         digit_sel;
    logic                          frame_start;
`ifdef DISPLAY_DIM_EN
    logic                          dim;
`endif

    modport master (
        output enable, wr_en, wr_addr, wr_data, commit_req,
`ifdef DISPLAY_DIM_EN
        output dim,
`endif
        input  commit_ack, code_out, digit_sel, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data, commit_req,
`ifdef DISPLAY_DIM_EN
        input  dim,
`endif
        output commit_ack, code_out, digit_sel, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits with a
// double-buffered code store. Define DISPLAY_DIM_EN to add the half-duty dim input.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    display_scan_ctrl_if.slave      scan_bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [IDX_W-1:0]      IDX_LAST       = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST       = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST     = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W:0]        NUM_DIGITS_EXT = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF        = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] SEL_ONE        = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
`ifdef DISPLAY_DIM_EN
    localparam logic [CNT_W-1:0]      DIM_END        =
        CNT_W'(BLANK_CYCLES + (PRESCALE - BLANK_CYCLES) / 2);
`endif

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4:0]            r_code_out;
    logic [NUM_DIGITS-1:0] r_digit_sel;
    logic                  r_frame_start;
    logic                  r_commit_ack;
    logic [4:0]            r_shadow [NUM_DIGITS];
    logic [4:0]            r_active [NUM_DIGITS];

    logic                  w_slot_end;
    logic                  w_copy;
    logic                  w_wr_ok;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [NUM_DIGITS-1:0] w_sel_show;
    logic [4:0]            w_active_nxt [NUM_DIGITS];

    // Next-cycle helpers: slot timing, commit decision and the post-edge active bank.
    always_comb begin
        w_slot_end = (r_cnt == CNT_LAST);
        w_cnt_inc  = r_cnt + CNT_W'(1'b1);
        w_idx_inc  = (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1'b1));
        w_wr_ok    = scan_bus.wr_en && ({1'b0, scan_bus.wr_addr} < NUM_DIGITS_EXT);
        // The ack cycle itself never starts a copy; a held request re-arms one cycle later.
        w_copy     = scan_bus.commit_req && !r_commit_ack &&
                     ((r_state == ST_OFF) ||
                      ((r_state == ST_SHOW) && (r_idx == IDX_LAST) && w_slot_end));
`ifdef DISPLAY_DIM_EN
        w_sel_show = (scan_bus.dim && (w_cnt_inc >= DIM_END)) ? SEL_OFF : ~(SEL_ONE << r_idx);
`else
        w_sel_show = ~(SEL_ONE << r_idx);
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_active_nxt[i] = w_copy ? r_shadow[i] : r_active[i];
        end
    end

    // Shadow/active code banks: writes land in shadow, commits copy the pre-write shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= 5'd0;
                r_active[i] <= 5'd0;
            end
        end else begin
            if (w_copy) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_wr_ok) begin
                r_shadow[scan_bus.wr_addr] <= scan_bus.wr_data;
            end
        end
    end

    // Scan FSM with prescaler; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_cnt         <= {CNT_W{1'b0}};
            r_idx         <= {IDX_W{1'b0}};
            r_code_out    <= 5'd0;
            r_digit_sel   <= SEL_OFF;
            r_frame_start <= 1'b0;
            r_commit_ack  <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_commit_ack  <= w_copy;
            if (!scan_bus.enable) begin
                r_state     <= ST_OFF;
                r_cnt       <= {CNT_W{1'b0}};
                r_idx       <= {IDX_W{1'b0}};
                r_code_out  <= 5'd0;
                r_digit_sel <= SEL_OFF;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state       <= ST_BLANK;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_idx         <= {IDX_W{1'b0}};
                        r_frame_start <= 1'b1;
                        r_code_out    <= w_active_nxt[0];
                        r_digit_sel   <= SEL_OFF;
                    end
                    ST_BLANK: begin
                        r_cnt      <= w_cnt_inc;
                        r_code_out <= w_active_nxt[r_idx];
                        if (r_cnt == BLANK_LAST) begin
                            r_state     <= ST_SHOW;
                            r_digit_sel <= w_sel_show;
                        end else begin
                            r_state     <= ST_BLANK;
                            r_digit_sel <= SEL_OFF;
                        end
                    end
                    ST_SHOW: begin
                        if (w_slot_end) begin
                            r_state       <= ST_BLANK;
                            r_cnt         <= {CNT_W{1'b0}};
                            r_idx         <= w_idx_inc;
                            r_frame_start <= (r_idx == IDX_LAST);
                            r_code_out    <= w_active_nxt[w_idx_inc];
                            r_digit_sel   <= SEL_OFF;
                        end else begin
                            r_state     <= ST_SHOW;
                            r_cnt       <= w_cnt_inc;
                            r_code_out  <= w_active_nxt[r_idx];
                            r_digit_sel <= w_sel_show;
                        end
                    end
                    default: begin
                        r_state     <= ST_OFF;
                        r_cnt       <= {CNT_W{1'b0}};
                        r_idx       <= {IDX_W{1'b0}};
                        r_code_out  <= 5'd0;
                        r_digit_sel <= SEL_OFF;
                    end
                endcase
            end
        end
    end

    assign scan_bus.code_out    = r_code_out;
    assign scan_bus.digit_sel   = r_digit_sel;
    assign scan_bus.frame_start = r_frame_start;
    assign scan_bus.commit_ack  = r_commit_ack;
endmodule
